// File: rtl/benes_switch_sequencer_pkg.sv
// Shared sizing, types and latency helper for the Benes switch sequencer.
// Build option BENES_SEQ_SKEW_EN (used by the top) selects per-stage skewed switch words.
package FHE_ALU_PKG;

  localparam int SIZE       = 16;
  localparam int SWITCH_NUM = SIZE / 2;
  localparam int STAGE_NUM  = 2 * $clog2(SIZE) - 1;
  localparam int PERM_NUM   = 16;
  localparam int STAGE_LAT  = 2;
  localparam int LAST_LAT   = 1;

  typedef logic [$clog2(PERM_NUM)-1:0] perm_id_t;
  typedef logic [SWITCH_NUM-1:0]       sw_word_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_e;

  // Cycles from fire to out_valid: one cycle to reach stage 0 i_port, then the stage chain.
  function automatic int net_latency(input int stage_num, input int stage_lat, input int last_lat);
    return 1 + (stage_num - 1) * stage_lat + last_lat;
  endfunction

endpackage

// File: rtl/benes_switch_sequencer_cfg_table.sv
// Switch-setting table: [PERM_NUM][STAGE_NUM] words, one write port, one read port per stage.
// Read port s looks up the word for stage s of the permutation given on rd_id_i[s].
module benes_cfg_table #(
  parameter  int PERM_NUM   = FHE_ALU_PKG::PERM_NUM,
  parameter  int STAGE_NUM  = FHE_ALU_PKG::STAGE_NUM,
  parameter  int SWITCH_NUM = FHE_ALU_PKG::SWITCH_NUM,
  localparam int PID_W      = $clog2(PERM_NUM),
  localparam int STG_W      = $clog2(STAGE_NUM)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  we_i,
  input  logic [PID_W-1:0]                      wr_id_i,
  input  logic [STG_W-1:0]                      wr_stage_i,
  input  logic [SWITCH_NUM-1:0]                 wr_word_i,
  input  logic [STAGE_NUM-1:0][PID_W-1:0]       rd_id_i,
  output logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]  rd_word_o
);

  localparam logic [STG_W-1:0] LAST_STG = STG_W'(STAGE_NUM - 1);

  logic [PERM_NUM-1:0][STAGE_NUM-1:0][SWITCH_NUM-1:0] mem_q;

  // Writes naming a stage beyond the network are silently dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (we_i && (wr_stage_i <= LAST_STG)) begin
      mem_q[wr_id_i][wr_stage_i] <= wr_word_i;
    end
  end

  for (genvar s = 0; s < STAGE_NUM; s++) begin : g_rd
    assign rd_word_o[s] = mem_q[rd_id_i[s]][s];
  end

endmodule

// File: rtl/benes_switch_sequencer.sv
// Drives Benes network switch_set from stored permutation tables, tracking frames in flight.
// BENES_SEQ_SKEW_EN: per-stage skewed words; otherwise all stages follow the last fired ID.
module benes_switch_sequencer #(
  parameter  int SIZE       = FHE_ALU_PKG::SIZE,
  parameter  int SWITCH_NUM = SIZE / 2,
  parameter  int STAGE_NUM  = 2 * $clog2(SIZE) - 1,
  parameter  int PERM_NUM   = FHE_ALU_PKG::PERM_NUM,
  parameter  int STAGE_LAT  = FHE_ALU_PKG::STAGE_LAT,
  parameter  int LAST_LAT   = FHE_ALU_PKG::LAST_LAT,
  localparam int PID_W      = $clog2(PERM_NUM),
  localparam int STG_W      = $clog2(STAGE_NUM)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_we,
  output logic                                  cfg_ready,
  input  logic [PID_W-1:0]                      cfg_perm_id,
  input  logic [STG_W-1:0]                      cfg_stage,
  input  logic [SWITCH_NUM-1:0]                 cfg_word,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [PID_W-1:0]                      in_perm_id,
  output logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]  switch_set,
  output logic                                  out_valid,
  output logic [PID_W-1:0]                      out_perm_id,
  output logic                                  busy
);
  import FHE_ALU_PKG::*;

  localparam int DEPTH = net_latency(STAGE_NUM, STAGE_LAT, LAST_LAT);
  localparam int CNT_W = $clog2(STAGE_NUM * STAGE_LAT + LAST_LAT + 1);

  seq_state_e                           state_q;
  logic [CNT_W-1:0]                     count_q, count_d;
  logic [DEPTH:1]                       vld_pipe_q;
  logic [DEPTH:1][PID_W-1:0]            id_pipe_q;
  logic [STAGE_NUM-1:0][PID_W-1:0]      rd_id;
  logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] rd_word;
  logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] switch_set_q;
  logic                                 fire;
  logic                                 cfg_acc;

  assign fire    = in_valid & in_ready;
  assign cfg_acc = cfg_we & cfg_ready;

  benes_cfg_table #(
    .PERM_NUM   (PERM_NUM),
    .STAGE_NUM  (STAGE_NUM),
    .SWITCH_NUM (SWITCH_NUM)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .we_i       (cfg_acc),
    .wr_id_i    (cfg_perm_id),
    .wr_stage_i (cfg_stage),
    .wr_word_i  (cfg_word),
    .rd_id_i    (rd_id),
    .rd_word_o  (rd_word)
  );

  // Token k of the pipe is live during the k-th cycle after its fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[DEPTH-1:1], fire};
      id_pipe_q  <= {id_pipe_q[DEPTH-1:1], in_perm_id};
    end
  end

`ifdef BENES_SEQ_SKEW_EN
  logic [STAGE_NUM-1:0] rd_vld;

  // Stage s word is loaded one cycle before its token goes live so the register lines up.
  assign rd_vld[0] = fire;
  assign rd_id[0]  = in_perm_id;
  for (genvar s = 1; s < STAGE_NUM; s++) begin : g_tap
    assign rd_vld[s] = vld_pipe_q[s*STAGE_LAT];
    assign rd_id[s]  = id_pipe_q[s*STAGE_LAT];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      switch_set_q <= '0;
    end else begin
      for (int s = 0; s < STAGE_NUM; s++) begin
        if (rd_vld[s]) switch_set_q[s] <= rd_word[s];
      end
    end
  end
`else
  logic [PID_W-1:0] cur_id_q;
  logic [PID_W-1:0] sel_id;

  assign sel_id = fire ? in_perm_id : cur_id_q;
  for (genvar s = 0; s < STAGE_NUM; s++) begin : g_tap
    assign rd_id[s] = sel_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_id_q     <= '0;
      switch_set_q <= '0;
    end else begin
      if (fire) cur_id_q <= in_perm_id;
      switch_set_q <= rd_word;
    end
  end
`endif

  always_comb begin
    count_d = count_q;
    if (fire && !out_valid)      count_d = count_q + CNT_W'(1);
    else if (!fire && out_valid) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      case (state_q)
        IDLE:    if (fire) state_q <= RUN;
        RUN: begin
          if (cfg_we)                state_q <= DRAIN;
          else if (count_d == '0)    state_q <= IDLE;
        end
        DRAIN:   if (count_d == '0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Config wins over issue; table writes only land with the pipeline empty.
  always_comb begin
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          cfg_ready = cfg_we;
          in_ready  = !cfg_we;
        end
        RUN:     in_ready = !cfg_we;
        default: ;
      endcase
    end
`ifndef BENES_SEQ_SKEW_EN
    if (busy && (in_perm_id != cur_id_q)) in_ready = 1'b0;
`endif
  end

  assign switch_set  = switch_set_q;
  assign out_valid   = vld_pipe_q[DEPTH];
  assign out_perm_id = id_pipe_q[DEPTH];
  assign busy        = (count_q != '0);

endmodule
